// File: rtl/mem_xbar.sv
// rtl/mem_xbar.sv - multi-master/multi-slave memory crossbar with one-entry request buffer per master
// Define MEM_XBAR_RR_EN for per-slave round-robin arbitration; otherwise the highest master index wins.
module mem_xbar #(
  parameter int MASTERS = 2,
  parameter int SLAVES = 3,
  parameter logic [SLAVES*32-1:0] BASE_ADDR = {32'h80000000, 32'h10000000, 32'h02000000},
  parameter logic [SLAVES*32-1:0] TOP_ADDR = {32'h80100000, 32'h10001000, 32'h0200C000}
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [MASTERS-1:0]     m_valid,
  input  logic [MASTERS-1:0]     m_instr,
  input  logic [MASTERS*32-1:0]  m_addr,
  input  logic [MASTERS*32-1:0]  m_wdata,
  input  logic [MASTERS*4-1:0]   m_wstrb,
  output logic [MASTERS*32-1:0]  m_rdata,
  output logic [MASTERS-1:0]     m_ready,
  output logic [MASTERS-1:0]     m_err,
  output logic [SLAVES-1:0]      s_valid,
  output logic [SLAVES-1:0]      s_instr,
  output logic [SLAVES*32-1:0]   s_addr,
  output logic [SLAVES*32-1:0]   s_wdata,
  output logic [SLAVES*4-1:0]    s_wstrb,
  input  logic [SLAVES*32-1:0]   s_rdata,
  input  logic [SLAVES-1:0]      s_ready
);
  localparam int MW = (MASTERS > 1) ? $clog2(MASTERS) : 1;
  localparam int SW = (SLAVES > 1) ? $clog2(SLAVES) : 1;

  typedef enum logic [1:0] {M_IDLE, M_PEND, M_WAIT, M_ERR} mst_state_t;

  mst_state_t        mst_state [MASTERS];
  logic [31:0]       buf_addr  [MASTERS];
  logic [31:0]       buf_wdata [MASTERS];
  logic [3:0]        buf_wstrb [MASTERS];
  logic [SW-1:0]     buf_tgt   [MASTERS];
  logic [MASTERS-1:0] buf_instr;
  logic [SLAVES-1:0] slv_busy;
  logic [MW-1:0]     slv_owner [SLAVES];
`ifdef MEM_XBAR_RR_EN
  logic [MW-1:0]     rr_ptr    [SLAVES];
`endif

  logic [MASTERS-1:0] live_hit, req_act, req_instr, mst_gnt;
  logic [SW-1:0]      live_tgt  [MASTERS];
  logic [SW-1:0]      req_tgt   [MASTERS];
  logic [31:0]        req_addr  [MASTERS];
  logic [31:0]        req_wdata [MASTERS];
  logic [3:0]         req_wstrb [MASTERS];
  logic [SLAVES-1:0]  slv_gnt;
  logic [MW-1:0]      slv_win   [SLAVES];

  // Descending scan so overlapping windows resolve to the lowest slave index.
  always_comb begin
    for (int m = 0; m < MASTERS; m++) begin
      live_hit[m] = 1'b0;
      live_tgt[m] = '0;
      for (int i = SLAVES - 1; i >= 0; i--) begin
        if (m_addr[m*32 +: 32] >= BASE_ADDR[i*32 +: 32] && m_addr[m*32 +: 32] < TOP_ADDR[i*32 +: 32]) begin
          live_hit[m] = 1'b1;
          live_tgt[m] = SW'(i);
        end
      end
      if (mst_state[m] == M_PEND) begin
        req_act[m]   = 1'b1;
        req_tgt[m]   = buf_tgt[m];
        req_addr[m]  = buf_addr[m];
        req_wdata[m] = buf_wdata[m];
        req_wstrb[m] = buf_wstrb[m];
        req_instr[m] = buf_instr[m];
      end else begin
        req_act[m]   = (mst_state[m] == M_IDLE) && m_valid[m] && live_hit[m];
        req_tgt[m]   = live_tgt[m];
        req_addr[m]  = m_addr[m*32 +: 32];
        req_wdata[m] = m_wdata[m*32 +: 32];
        req_wstrb[m] = m_wstrb[m*4 +: 4];
        req_instr[m] = m_instr[m];
      end
    end
  end

  // A slave completing this cycle can be re-granted in the same cycle.
  always_comb begin
`ifdef MEM_XBAR_RR_EN
    int k;
`endif
    for (int i = 0; i < SLAVES; i++) begin
      slv_gnt[i] = 1'b0;
      slv_win[i] = '0;
`ifdef MEM_XBAR_RR_EN
      for (int off = MASTERS - 1; off >= 0; off--) begin
        k = (int'(rr_ptr[i]) + off) % MASTERS;
        if (req_act[k] && req_tgt[k] == SW'(i) && (!slv_busy[i] || s_ready[i])) begin
          slv_gnt[i] = 1'b1;
          slv_win[i] = MW'(k);
        end
      end
`else
      for (int m = 0; m < MASTERS; m++) begin
        if (req_act[m] && req_tgt[m] == SW'(i) && (!slv_busy[i] || s_ready[i])) begin
          slv_gnt[i] = 1'b1;
          slv_win[i] = MW'(m);
        end
      end
`endif
    end
  end

  always_comb begin
    mst_gnt = '0;
    for (int i = 0; i < SLAVES; i++)
      if (slv_gnt[i]) mst_gnt[slv_win[i]] = 1'b1;
  end

  // Outputs are forced low during reset so an aborted request never completes.
  always_comb begin
    s_valid = '0;
    s_instr = '0;
    s_addr  = '0;
    s_wdata = '0;
    s_wstrb = '0;
    m_ready = '0;
    m_err   = '0;
    m_rdata = '0;
    if (!rst) begin
      for (int i = 0; i < SLAVES; i++) begin
        if (slv_gnt[i]) begin
          s_valid[i]          = 1'b1;
          s_instr[i]          = req_instr[slv_win[i]];
          s_addr[i*32 +: 32]  = req_addr[slv_win[i]] - BASE_ADDR[i*32 +: 32];
          s_wdata[i*32 +: 32] = req_wdata[slv_win[i]];
          s_wstrb[i*4 +: 4]   = req_wstrb[slv_win[i]];
        end
        if (slv_busy[i] && s_ready[i]) begin
          m_ready[slv_owner[i]]                   = 1'b1;
          m_rdata[int'(slv_owner[i])*32 +: 32]    = s_rdata[i*32 +: 32];
        end
      end
      for (int m = 0; m < MASTERS; m++) begin
        if (mst_state[m] == M_ERR) begin
          m_ready[m] = 1'b1;
          m_err[m]   = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int m = 0; m < MASTERS; m++) begin
        mst_state[m] <= M_IDLE;
        buf_addr[m]  <= '0;
        buf_wdata[m] <= '0;
        buf_wstrb[m] <= '0;
        buf_tgt[m]   <= '0;
      end
      buf_instr <= '0;
      slv_busy  <= '0;
      for (int i = 0; i < SLAVES; i++) begin
        slv_owner[i] <= '0;
`ifdef MEM_XBAR_RR_EN
        rr_ptr[i]    <= '0;
`endif
      end
    end else begin
      for (int m = 0; m < MASTERS; m++) begin
        case (mst_state[m])
          M_IDLE: if (m_valid[m]) begin
            if (!live_hit[m]) mst_state[m] <= M_ERR;
            else if (mst_gnt[m]) mst_state[m] <= M_WAIT;
            else begin
              mst_state[m] <= M_PEND;
              buf_addr[m]  <= m_addr[m*32 +: 32];
              buf_wdata[m] <= m_wdata[m*32 +: 32];
              buf_wstrb[m] <= m_wstrb[m*4 +: 4];
              buf_instr[m] <= m_instr[m];
              buf_tgt[m]   <= live_tgt[m];
            end
          end
          M_PEND: if (mst_gnt[m]) mst_state[m] <= M_WAIT;
          M_WAIT: if (m_ready[m]) mst_state[m] <= M_IDLE;
          default: mst_state[m] <= M_IDLE;
        endcase
      end
      for (int i = 0; i < SLAVES; i++) begin
        if (slv_gnt[i]) begin
          slv_busy[i]  <= 1'b1;
          slv_owner[i] <= slv_win[i];
`ifdef MEM_XBAR_RR_EN
          rr_ptr[i]    <= MW'((int'(slv_win[i]) + 1) % MASTERS);
`endif
        end else if (s_ready[i]) begin
          slv_busy[i] <= 1'b0;
        end
      end
    end
  end
endmodule

// File: tb/tb_mem_xbar.sv
// tb/tb_mem_xbar.sv - directed bench for mem_xbar with a transaction-level reference model
// Build with or without MEM_XBAR_RR_EN; expectations follow the selected arbitration mode.
module tb_mem_xbar;
  localparam int M = 2;
  localparam int S = 3;
`ifdef MEM_XBAR_RR_EN
  localparam bit RR = 1'b1;
`else
  localparam bit RR = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [M-1:0]    m_valid = '0, m_instr = '0;
  logic [M*32-1:0] m_addr = '0, m_wdata = '0;
  logic [M*4-1:0]  m_wstrb = '0;
  logic [M*32-1:0] m_rdata;
  logic [M-1:0]    m_ready, m_err;
  logic [S-1:0]    s_valid, s_instr;
  logic [S*32-1:0] s_addr, s_wdata;
  logic [S*4-1:0]  s_wstrb;
  logic [S*32-1:0] s_rdata = '0;
  logic [S-1:0]    s_ready = '0;

  int tests = 0;
  int fails = 0;
  int s1_pulses = 0;

  always #5 clk = ~clk;

  mem_xbar dut (
    .clk(clk), .rst(rst),
    .m_valid(m_valid), .m_instr(m_instr), .m_addr(m_addr), .m_wdata(m_wdata), .m_wstrb(m_wstrb),
    .m_rdata(m_rdata), .m_ready(m_ready), .m_err(m_err),
    .s_valid(s_valid), .s_instr(s_instr), .s_addr(s_addr), .s_wdata(s_wdata), .s_wstrb(s_wstrb),
    .s_rdata(s_rdata), .s_ready(s_ready)
  );

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Address map as slave-indexed tables.
  logic [31:0] base_a [S] = '{32'h02000000, 32'h10000000, 32'h80000000};
  logic [31:0] top_a  [S] = '{32'h0200C000, 32'h10001000, 32'h80100000};

  function automatic int decode(input logic [31:0] a);
    decode = -1;
    for (int s = S - 1; s >= 0; s--)
      if (a >= base_a[s] && a < top_a[s]) decode = s;
  endfunction

  // Model state: slave owner (-1 = free), per-master outstanding/held/error flags.
  int          own [S];
  int          rrp [S];
  bit          waiting [M], pend [M], errq [M];
  logic [31:0] pa [M], pw [M];
  logic [3:0]  ps [M];
  logic        pi [M];
  int          pt [M];

  always @(negedge clk) begin : model_p
    logic [M-1:0]    e_ready, e_err, cand, newerr;
    logic [M*32-1:0] e_rdata;
    logic [S-1:0]    e_sv, e_si;
    logic [S*32-1:0] e_sa, e_sw;
    logic [S*4-1:0]  e_ss;
    logic [31:0]     ra [M], rw [M];
    logic [3:0]      rs [M];
    logic            ri [M];
    int              rt [M];
    int              win [S];
    int              k;
    e_ready = '0; e_err = '0; e_rdata = '0;
    e_sv = '0; e_si = '0; e_sa = '0; e_sw = '0; e_ss = '0;
    cand = '0; newerr = '0;
    if (s_valid[1]) s1_pulses++;
    if (rst) begin
      for (int s = 0; s < S; s++) begin own[s] = -1; rrp[s] = 0; end
      for (int m = 0; m < M; m++) begin waiting[m] = 0; pend[m] = 0; errq[m] = 0; end
    end else begin
      for (int m = 0; m < M; m++)
        if (errq[m]) begin e_ready[m] = 1'b1; e_err[m] = 1'b1; end
      for (int s = 0; s < S; s++)
        if (own[s] >= 0 && s_ready[s]) begin
          e_ready[own[s]] = 1'b1;
          e_rdata[own[s]*32 +: 32] = s_rdata[s*32 +: 32];
        end
      for (int m = 0; m < M; m++) begin
        rt[m] = -1; ra[m] = '0; rw[m] = '0; rs[m] = '0; ri[m] = 1'b0;
        if (pend[m]) begin
          cand[m] = 1'b1; ra[m] = pa[m]; rw[m] = pw[m]; rs[m] = ps[m]; ri[m] = pi[m]; rt[m] = pt[m];
        end else if (!waiting[m] && !errq[m] && m_valid[m]) begin
          rt[m] = decode(m_addr[m*32 +: 32]);
          if (rt[m] < 0) newerr[m] = 1'b1;
          else begin
            cand[m] = 1'b1; ra[m] = m_addr[m*32 +: 32]; rw[m] = m_wdata[m*32 +: 32];
            rs[m] = m_wstrb[m*4 +: 4]; ri[m] = m_instr[m];
          end
        end
      end
      for (int s = 0; s < S; s++) begin
        win[s] = -1;
        if (own[s] < 0 || s_ready[s]) begin
          for (int n = 0; n < M; n++) begin
            k = RR ? (rrp[s] + n) % M : M - 1 - n;
            if (win[s] < 0 && cand[k] && rt[k] == s) win[s] = k;
          end
        end
        if (win[s] >= 0) begin
          e_sv[s] = 1'b1;
          e_si[s] = ri[win[s]];
          e_sa[s*32 +: 32] = ra[win[s]] - base_a[s];
          e_sw[s*32 +: 32] = rw[win[s]];
          e_ss[s*4 +: 4]   = rs[win[s]];
        end
      end
      for (int s = 0; s < S; s++)
        if (own[s] >= 0 && s_ready[s]) begin waiting[own[s]] = 0; own[s] = -1; end
      for (int m = 0; m < M; m++) errq[m] = newerr[m];
      for (int s = 0; s < S; s++)
        if (win[s] >= 0) begin
          own[s] = win[s]; waiting[win[s]] = 1; pend[win[s]] = 0; cand[win[s]] = 1'b0;
          rrp[s] = (win[s] + 1) % M;
        end
      for (int m = 0; m < M; m++)
        if (cand[m] && !pend[m]) begin
          pend[m] = 1; pa[m] = ra[m]; pw[m] = rw[m]; ps[m] = rs[m]; pi[m] = ri[m]; pt[m] = rt[m];
        end
    end
    chk("mdl_m_ready", m_ready, e_ready);
    chk("mdl_m_err", m_err, e_err);
    chk("mdl_m_rdata", m_rdata, e_rdata);
    chk("mdl_s_valid", s_valid, e_sv);
    chk("mdl_s_instr", s_instr, e_si);
    chk("mdl_s_addr", s_addr, e_sa);
    chk("mdl_s_wdata", s_wdata, e_sw);
    chk("mdl_s_wstrb", s_wstrb, e_ss);
  end

  task automatic step();
    @(posedge clk);
    #1;
    m_valid = '0;
    s_ready = '0;
  endtask

  task automatic req(input int m, input logic [31:0] a, input logic [31:0] d, input logic [3:0] st,
                     input logic ins);
    m_valid[m] = 1'b1;
    m_instr[m] = ins;
    m_addr[m*32 +: 32] = a;
    m_wdata[m*32 +: 32] = d;
    m_wstrb[m*4 +: 4] = st;
  endtask

  task automatic rsp(input int s, input logic [31:0] d);
    s_ready[s] = 1'b1;
    s_rdata[s*32 +: 32] = d;
  endtask

  initial begin
    int base;
    step(); step();
    rst = 1'b0;
    #5;
    chk("rst_s_valid", s_valid, 0);
    chk("rst_m_ready", m_ready, 0);
    chk("rst_m_rdata", m_rdata, 0);
    step();

    req(1, 32'h10000004, 32'h0, 4'h0, 1'b0); #5;
    chk("rd_s_valid", s_valid, 3'b010);
    chk("rd_s_addr", s_addr[63:32], 32'h4);
    step(); step();
    rsp(1, 32'hA5); #5;
    chk("rd_m_ready", m_ready, 2'b10);
    chk("rd_m_rdata", m_rdata[63:32], 32'hA5);
    chk("rd_m_err", m_err, 0);
    step();

    req(0, 32'h80000010, 32'h11111111, 4'h0, 1'b0);
    req(1, 32'h80000010, 32'h22222222, 4'h0, 1'b0); #5;
    chk("cf1_s_valid", s_valid, 3'b100);
    chk("cf1_s_addr", s_addr[95:64], 32'h10);
    chk("cf1_first", s_wdata[95:64], RR ? 32'h11111111 : 32'h22222222);
    step(); step();
    rsp(2, 32'h33); #5;
    chk("cf1_ready1", m_ready, RR ? 2'b01 : 2'b10);
    chk("cf1_second_sv", s_valid, 3'b100);
    chk("cf1_second", s_wdata[95:64], RR ? 32'h22222222 : 32'h11111111);
    step();
    rsp(2, 32'h44); #5;
    chk("cf1_ready2", m_ready, RR ? 2'b10 : 2'b01);
    step();
    req(0, 32'h80000000, 32'h0, 4'h0, 1'b0); step();
    rsp(2, 32'h55); step();

    req(0, 32'h80000010, 32'h11111111, 4'h0, 1'b0);
    req(1, 32'h80000010, 32'h22222222, 4'h0, 1'b0); #5;
    chk("cf2_first", s_wdata[95:64], 32'h22222222);
    step();
    rsp(2, 32'h56); #5;
    chk("cf2_ready1", m_ready, 2'b10);
    chk("cf2_second", s_wdata[95:64], 32'h11111111);
    step();
    rsp(2, 32'h57); #5;
    chk("cf2_ready2", m_ready, 2'b01);
    step();

    req(0, 32'h40000000, 32'h0, 4'h0, 1'b0); #5;
    chk("de_no_s_valid", s_valid, 0);
    chk("de_no_ready_yet", m_ready, 0);
    step(); #5;
    chk("de_m_ready", m_ready, 2'b01);
    chk("de_m_err", m_err, 2'b01);
    chk("de_m_rdata", m_rdata[31:0], 32'h0);
    step();
    req(1, 32'h10001000, 32'h0, 4'h0, 1'b0); #5;
    chk("top_excl_sv", s_valid, 0);
    step(); #5;
    chk("top_excl_err", m_err, 2'b10);
    step();
    req(0, 32'h0200BFFC, 32'h0, 4'h0, 1'b0); #5;
    chk("top_last_sv", s_valid, 3'b001);
    chk("top_last_addr", s_addr[31:0], 32'hBFFC);
    step();
    rsp(0, 32'h99); #5;
    chk("top_last_rdata", m_rdata[31:0], 32'h99);
    step();

    req(0, 32'h80000000, 32'h0, 4'h0, 1'b1);
    req(1, 32'h02000000, 32'h0, 4'h0, 1'b0); #5;
    chk("par_s_valid", s_valid, 3'b101);
    chk("par_s_instr", s_instr, 3'b100);
    chk("par_s_addr2", s_addr[95:64], 32'h0);
    chk("par_s_addr0", s_addr[31:0], 32'h0);
    step();
    rsp(0, 32'h77); #5;
    chk("par_ready1", m_ready, 2'b10);
    chk("par_rdata1", m_rdata[63:32], 32'h77);
    step();
    rsp(2, 32'h88); #5;
    chk("par_ready0", m_ready, 2'b01);
    chk("par_rdata0", m_rdata[31:0], 32'h88);
    step();

    req(0, 32'h80000020, 32'h0, 4'h0, 1'b0); step();
    req(1, 32'h80000024, 32'hBEEF, 4'hF, 1'b0); #5;
    chk("rm_pend_sv", s_valid, 0);
    step();
    rst = 1'b1; step();
    rst = 1'b0; #5;
    chk("rm_s_valid", s_valid, 0);
    chk("rm_m_ready", m_ready, 0);
    chk("rm_m_err", m_err, 0);
    chk("rm_m_rdata", m_rdata, 0);
    step();
    rsp(2, 32'h66); #5;
    chk("rm_stray_ready", m_ready, 0);
    chk("rm_stray_sv", s_valid, 0);
    step(); step(); #5;
    chk("rm_never_issued", s_valid, 0);
    step();

    base = s1_pulses;
    for (int i = 0; i < 4; i++) begin
      req(1, 32'h10000000, 32'hD0000000 + i, 4'hF, 1'b0); #5;
      chk("b2b_s_valid", s_valid, 3'b010);
      chk("b2b_wdata", s_wdata[63:32], 32'hD0000000 + i);
      chk("b2b_wstrb", s_wstrb[7:4], 4'hF);
      step();
      rsp(1, 32'h0); #5;
      chk("b2b_m_ready", m_ready, 2'b10);
      step();
    end
    step();
    chk("b2b_pulses", s1_pulses - base, 4);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
